// File: rtl/reg_file.sv
// 32-entry register file with two combinational read ports, one write port,
// optional same-cycle write-to-read forwarding and a committed-write counter.
// Register 0 is hard-wired to zero.
module reg_file #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RFWE,
  input  logic [4:0]       RFWA,
  input  logic [WIDTH-1:0] RFWD,
  input  logic [4:0]       RFRA1,
  input  logic [4:0]       RFRA2,
  output logic [WIDTH-1:0] RFRD1,
  output logic [WIDTH-1:0] RFRD2,
  output logic [15:0]      WrCnt
);

  logic [WIDTH-1:0] regs_q [32];
  logic [WIDTH-1:0] regs_d [32];
  logic [15:0]      wr_cnt_q;
  logic [15:0]      wr_cnt_d;
  logic             commit;

  // Write commit qualification: writes to r0 are dropped and not counted.
  always_comb begin
    commit = RFWE && (RFWA != 5'd0);
  end

  // Next-state for storage and write counter.
  always_comb begin
    regs_d   = regs_q;
    wr_cnt_d = wr_cnt_q;
    if (commit) begin
      regs_d[RFWA] = RFWD;
      wr_cnt_d     = wr_cnt_q + 16'd1;
    end
    regs_d[0] = '0;
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q   <= '{default: '0};
      wr_cnt_q <= '0;
    end else begin
      regs_q   <= regs_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Read ports with optional forwarding of the in-flight write; forwarding is
  // gated by rst_n so outputs stay zero while reset is held.
  always_comb begin
    RFRD1 = regs_q[RFRA1];
    RFRD2 = regs_q[RFRA2];
    if ((BYPASS != 0) && rst_n && commit) begin
      if (RFWA == RFRA1) RFRD1 = RFWD;
      if (RFWA == RFRA2) RFRD2 = RFWD;
    end
  end

  // Debug counter output.
  always_comb begin
    WrCnt = wr_cnt_q;
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file; runs a forwarding and a
// non-forwarding instance side by side on the same stimulus.
module tb_reg_file;

  localparam int unsigned W = 32;

  logic          clk;
  logic          rst_n;
  logic          we;
  logic [4:0]    wa;
  logic [W-1:0]  wd;
  logic [4:0]    ra1;
  logic [4:0]    ra2;
  logic [W-1:0]  b_rd1, b_rd2, n_rd1, n_rd2;
  logic [15:0]   b_cnt, n_cnt;

  int unsigned   n_cmp;
  int unsigned   n_err;
  logic [15:0]   exp_cnt;

  reg_file #(.WIDTH(W), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .RFWE(we), .RFWA(wa), .RFWD(wd),
    .RFRA1(ra1), .RFRA2(ra2), .RFRD1(b_rd1), .RFRD2(b_rd2), .WrCnt(b_cnt)
  );

  reg_file #(.WIDTH(W), .BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .RFWE(we), .RFWA(wa), .RFWD(wd),
    .RFRA1(ra1), .RFRA2(ra2), .RFRD1(n_rd1), .RFRD2(n_rd2), .WrCnt(n_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Single committed write, both DUTs; leaves we low afterwards.
  task automatic do_write(input logic [4:0] a, input logic [W-1:0] d);
    @(negedge clk);
    we = 1'b1; wa = a; wd = d;
    @(posedge clk);
    #1;
    we = 1'b0;
    if (a != 5'd0) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; we = 1'b1; wa = 5'd4; wd = 32'hAAAA_5555; ra1 = 5'd4; ra2 = 5'd4;
    exp_cnt = '0;
    #2;
    // forwarding suppressed while reset is held
    n_cmp++;
    if (b_rd1 !== '0) begin n_err++; $display("FAIL reset_fwd_rd1 got=%h exp=0", b_rd1); end
    n_cmp++;
    if (b_rd2 !== '0) begin n_err++; $display("FAIL reset_fwd_rd2 got=%h exp=0", b_rd2); end
    @(posedge clk); #1;
    n_cmp++;
    if (b_cnt !== 16'd0) begin n_err++; $display("FAIL reset_edge_cnt got=%h exp=0", b_cnt); end
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      n_cmp++;
      if (b_rd1 !== '0) begin n_err++; $display("FAIL reset_read_b1 a=%0d got=%h exp=0", i, b_rd1); end
      n_cmp++;
      if (b_rd2 !== '0) begin n_err++; $display("FAIL reset_read_b2 a=%0d got=%h exp=0", 31 - i, b_rd2); end
      n_cmp++;
      if (n_rd1 !== '0) begin n_err++; $display("FAIL reset_read_n1 a=%0d got=%h exp=0", i, n_rd1); end
      n_cmp++;
      if (n_rd2 !== '0) begin n_err++; $display("FAIL reset_read_n2 a=%0d got=%h exp=0", 31 - i, n_rd2); end
    end
    n_cmp++;
    if (b_cnt !== 16'd0 || n_cnt !== 16'd0) begin
      n_err++; $display("FAIL reset_cnt got=%h/%h exp=0", b_cnt, n_cnt);
    end
  endtask

  task automatic test_write_read();
    do_write(5'd8, 32'hDEAD_BEEF);
    ra1 = 5'd8; ra2 = 5'd8;
    #1;
    n_cmp++;
    if (b_rd1 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_rd1 got=%h exp=deadbeef", b_rd1); end
    n_cmp++;
    if (b_rd2 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_rd2 got=%h exp=deadbeef", b_rd2); end
    n_cmp++;
    if (n_rd1 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_rd1_nb got=%h exp=deadbeef", n_rd1); end
    n_cmp++;
    if (b_cnt !== 16'd1) begin n_err++; $display("FAIL wr_cnt got=%h exp=1", b_cnt); end
  endtask

  task automatic test_write_zero();
    @(negedge clk);
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra1 = 5'd0; ra2 = 5'd0;
    #1;
    n_cmp++;
    if (b_rd1 !== '0) begin n_err++; $display("FAIL r0_nofwd got=%h exp=0", b_rd1); end
    @(posedge clk); #1;
    we = 1'b0;
    n_cmp++;
    if (b_rd1 !== '0) begin n_err++; $display("FAIL r0_read got=%h exp=0", b_rd1); end
    n_cmp++;
    if (n_rd2 !== '0) begin n_err++; $display("FAIL r0_read_nb got=%h exp=0", n_rd2); end
    n_cmp++;
    if (b_cnt !== exp_cnt) begin n_err++; $display("FAIL r0_cnt got=%h exp=%h", b_cnt, exp_cnt); end
  endtask

  task automatic test_no_enable();
    do_write(5'd9, 32'h1234_5678);
    @(negedge clk);
    we = 1'b0; wa = 5'd9; wd = 32'h8765_4321; ra1 = 5'd9; ra2 = 5'd9;
    #1;
    n_cmp++;
    if (b_rd1 !== 32'h1234_5678) begin n_err++; $display("FAIL noen_pre got=%h exp=12345678", b_rd1); end
    @(posedge clk); #1;
    n_cmp++;
    if (b_rd2 !== 32'h1234_5678) begin n_err++; $display("FAIL noen_post got=%h exp=12345678", b_rd2); end
    n_cmp++;
    if (n_cnt !== exp_cnt) begin n_err++; $display("FAIL noen_cnt got=%h exp=%h", n_cnt, exp_cnt); end
  endtask

  task automatic test_bypass();
    do_write(5'd5, 32'h11);
    @(negedge clk);
    we = 1'b1; wa = 5'd5; wd = 32'h22; ra1 = 5'd5; ra2 = 5'd5;
    #1;
    n_cmp++;
    if (b_rd1 !== 32'h22) begin n_err++; $display("FAIL byp_b1_pre got=%h exp=22", b_rd1); end
    n_cmp++;
    if (b_rd2 !== 32'h22) begin n_err++; $display("FAIL byp_b2_pre got=%h exp=22", b_rd2); end
    n_cmp++;
    if (n_rd1 !== 32'h11) begin n_err++; $display("FAIL byp_n1_pre got=%h exp=11", n_rd1); end
    n_cmp++;
    if (n_rd2 !== 32'h11) begin n_err++; $display("FAIL byp_n2_pre got=%h exp=11", n_rd2); end
    // one port matching, the other not
    ra2 = 5'd8;
    #1;
    n_cmp++;
    if (b_rd2 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL byp_other_port got=%h exp=deadbeef", b_rd2); end
    @(posedge clk); #1;
    we = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    n_cmp++;
    if (b_rd1 !== 32'h22) begin n_err++; $display("FAIL byp_b1_post got=%h exp=22", b_rd1); end
    n_cmp++;
    if (n_rd1 !== 32'h22) begin n_err++; $display("FAIL byp_n1_post got=%h exp=22", n_rd1); end
    n_cmp++;
    if (n_cnt !== exp_cnt) begin n_err++; $display("FAIL byp_cnt got=%h exp=%h", n_cnt, exp_cnt); end
  endtask

  task automatic test_async_reset();
    for (int i = 1; i < 32; i++) do_write(5'(i), W'(i));
    ra1 = 5'd7; ra2 = 5'd31;
    #1;
    n_cmp++;
    if (b_rd1 !== 32'd7 || b_rd2 !== 32'd31) begin
      n_err++; $display("FAIL ar_fill got=%h/%h exp=7/1f", b_rd1, b_rd2);
    end
    n_cmp++;
    if (b_cnt !== exp_cnt) begin n_err++; $display("FAIL ar_fill_cnt got=%h exp=%h", b_cnt, exp_cnt); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (b_rd1 !== '0 || b_rd2 !== '0 || n_rd1 !== '0 || n_rd2 !== '0) begin
      n_err++; $display("FAIL ar_async_rd got=%h/%h/%h/%h exp=0", b_rd1, b_rd2, n_rd1, n_rd2);
    end
    n_cmp++;
    if (b_cnt !== 16'd0 || n_cnt !== 16'd0) begin
      n_err++; $display("FAIL ar_async_cnt got=%h/%h exp=0", b_cnt, n_cnt);
    end
    // a write on an edge during reset is lost
    we = 1'b1; wa = 5'd7; wd = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    exp_cnt = '0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      #1;
      n_cmp++;
      if (b_rd1 !== '0) begin n_err++; $display("FAIL ar_clear a=%0d got=%h exp=0", i, b_rd1); end
    end
    // first write after release commits on the first edge
    do_write(5'd12, 32'hCAFE_F00D);
    ra1 = 5'd12;
    #1;
    n_cmp++;
    if (n_rd1 !== 32'hCAFE_F00D) begin n_err++; $display("FAIL ar_first_wr got=%h exp=cafef00d", n_rd1); end
    n_cmp++;
    if (n_cnt !== 16'd1) begin n_err++; $display("FAIL ar_first_cnt got=%h exp=1", n_cnt); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = '0;
    do_write(5'd3, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (b_cnt !== 16'd1) begin n_err++; $display("FAIL wrap_idle got=%h exp=1", b_cnt); end
    @(negedge clk);
    we = 1'b1; wa = 5'd3; wd = 32'h3333;
    repeat (65534) @(posedge clk);
    #1;
    n_cmp++;
    if (b_cnt !== 16'hFFFF) begin n_err++; $display("FAIL wrap_max got=%h exp=ffff", b_cnt); end
    @(posedge clk); #1;
    we = 1'b0;
    n_cmp++;
    if (b_cnt !== 16'h0000 || n_cnt !== 16'h0000) begin
      n_err++; $display("FAIL wrap_zero got=%h/%h exp=0", b_cnt, n_cnt);
    end
    ra1 = 5'd3;
    #1;
    n_cmp++;
    if (b_rd1 !== 32'h3333) begin n_err++; $display("FAIL wrap_data got=%h exp=3333", b_rd1); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; exp_cnt = '0;
    we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; rst_n = 1'b0;
    test_reset();
    test_write_read();
    test_write_zero();
    test_no_enable();
    test_bypass();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
